// File: rtl/board_input_debounce.sv
// board_input_debounce: synchronizes, debounces and edge-detects raw board inputs
module board_input_debounce #(
    parameter int unsigned          NumInputs    = 5,
    parameter int unsigned          StableCycles = 20000,
    parameter int unsigned          SyncStages   = 2,
    parameter logic [NumInputs-1:0] ResetValue   = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 debounce_en_i,
    input  logic [NumInputs-1:0] raw_i,
    output logic [NumInputs-1:0] level_o,
    output logic [NumInputs-1:0] rise_o,
    output logic [NumInputs-1:0] fall_o,
    output logic                 busy_o
);
    localparam int unsigned     CntW   = $clog2(StableCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

    (* ASYNC_REG = "TRUE" *) logic [NumInputs-1:0] sync_q [SyncStages];
    logic [NumInputs-1:0] sync, level_q, level_prev_q;
    logic [CntW-1:0]      cnt_q [NumInputs];

    assign sync = sync_q[SyncStages-1];

    // metastability chain: plain flop-to-flop, no logic between stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SyncStages; s++) sync_q[s] <= ResetValue;
        end else begin
            sync_q[0] <= raw_i;
            for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // per-channel stability filter; a match, bypass or a full count reloads level from sync
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q      <= ResetValue;
            level_prev_q <= ResetValue;
            for (int c = 0; c < NumInputs; c++) cnt_q[c] <= '0;
        end else begin
            level_prev_q <= level_q;
            for (int c = 0; c < NumInputs; c++) begin
                if (!debounce_en_i || sync[c] == level_q[c] || cnt_q[c] == CntMax) begin
                    cnt_q[c]   <= '0;
                    level_q[c] <= sync[c];
                end else begin
                    cnt_q[c] <= cnt_q[c] + 1'b1;
                end
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~level_prev_q;
    assign fall_o  = ~level_q & level_prev_q;
    assign busy_o  = |(sync ^ level_q);
endmodule

// File: tb/tb_board_input_debounce.sv
// tb_board_input_debounce: directed stimulus with a pulse scoreboard for board_input_debounce
module tb_board_input_debounce;
    localparam int N = 5;

    typedef struct {
        int cyc;
        int ch;
        bit up;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic [N-1:0] raw = '0;
    logic [N-1:0] level, rise, fall;
    logic         busy;
    int           cyc = 0;
    int           compared = 0;
    int           mismatched = 0;
    ev_t          exp_q[$];
    ev_t          mon_e;
    int           t0;
    int           bounce[6] = '{1, 0, 1, 1, 0, 1};

    board_input_debounce #(
        .NumInputs   (N),
        .StableCycles(4),
        .SyncStages  (2),
        .ResetValue  (5'b00000)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .debounce_en_i(en),
        .raw_i        (raw),
        .level_o      (level),
        .rise_o       (rise),
        .fall_o       (fall),
        .busy_o       (busy)
    );

    always #25 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(int at, int ch, bit up);
        exp_q.push_back('{at, ch, up});
    endtask

    // monitor: every observed pulse must match the oldest expected pulse
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (rise[c] || fall[c]) begin
                check("pulse_exclusive", {31'd0, rise[c] & fall[c]}, 32'd0);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_pulse: ch %0d rise %0b fall %0b at cycle %0d, none expected",
                             c, rise[c], fall[c], cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_cycle", cyc, mon_e.cyc);
                    check("pulse_channel", c, mon_e.ch);
                    check("pulse_dir_rise", {31'd0, rise[c]}, {31'd0, mon_e.up});
                end
            end
        end
    end

    initial begin
        tick(2);
        check("reset_level", level, 5'b00000);
        check("reset_rise", rise, 5'b00000);
        check("reset_fall", fall, 5'b00000);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
        tick(3);
        check("idle_level", level, 5'b00000);

        t0 = cyc;
        raw[0] = 1'b1;
        expect_pulse(t0 + 6, 0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("step_busy", busy, (k >= 2 && k <= 5) ? 1 : 0);
            check("step_level0", level[0], (k >= 6) ? 1 : 0);
        end

        raw[1] = 1'b1;
        tick(3);
        raw[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("glitch3_level1", level[1], 0);
        end
        check("glitch3_busy", busy, 0);
        check("glitch3_level", level, 5'b00001);

        t0 = cyc;
        raw[1] = 1'b1;
        expect_pulse(t0 + 6, 1, 1'b1);
        expect_pulse(t0 + 10, 1, 1'b0);
        tick(4);
        raw[1] = 1'b0;
        tick(10);
        check("pulse4_level", level, 5'b00001);

        t0 = cyc;
        expect_pulse(t0 + 11, 2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            raw[2] = (bounce[i] != 0);
            tick(1);
        end
        tick(8);
        check("bounce_level", level, 5'b00101);

        t0 = cyc;
        raw[4:3] = 2'b11;
        expect_pulse(t0 + 6, 3, 1'b1);
        expect_pulse(t0 + 6, 4, 1'b1);
        tick(8);
        check("simul_level", level, 5'b11101);
        t0 = cyc;
        raw[3] = 1'b0;
        expect_pulse(t0 + 6, 3, 1'b0);
        tick(8);
        check("indep_level", level, 5'b10101);

        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(2);
            raw[0] = ~raw[0];
            expect_pulse(cyc + 3, 0, raw[0]);
        end
        tick(6);
        check("bypass_level", level, 5'b10101);
        en = 1'b1;
        tick(2);
        raw[0] = 1'b0;
        expect_pulse(cyc + 6, 0, 1'b0);
        tick(10);
        check("reenable_level", level, 5'b10100);

        raw[1] = 1'b1;
        expect_pulse(cyc + 4, 1, 1'b1);
        tick(3);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        raw[1] = 1'b0;
        expect_pulse(cyc + 6, 1, 1'b0);
        tick(10);
        check("midcount_level", level, 5'b10100);

        raw = 5'b11111;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("rst_level", level, 5'b00000);
        check("rst_rise", rise, 5'b00000);
        check("rst_fall", fall, 5'b00000);
        check("rst_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        t0 = cyc;
        for (int c = 0; c < N; c++) expect_pulse(t0 + 6, c, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("post_rst_level", level, (k >= 6) ? 5'b11111 : 5'b00000);
        end
        check("post_rst_busy", busy, 0);

        tick(2);
        check("pending_pulses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
